// File: rtl/exec_mem_pkg.sv
// Shared ALU-control and alu_op encodings for the execute/memory slice.
// EXEC_MEM_XOR_EN (defined by the build) enables the XOR code in the decoder and ALU.
package exec_mem_pkg;

  localparam int ALU_CTRL_W = 3;
  localparam int ALU_OP_W   = 2;

  // ALU-control codes carried on alu_control
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  // Operation classes from the main decoder; 2'b11 decodes like FUNCT
  localparam logic [ALU_OP_W-1:0] ALU_OP_LDST   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT  = 2'b10;

  // funct3 values that select a distinct ALU operation
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU with zero flag; no latency, no flow control.
// EXEC_MEM_XOR_EN adds a^b on code 100; otherwise unused codes return 0.
module exec_alu
  import exec_mem_pkg::*;
(
  input  logic [31:0]           a,
  input  logic [31:0]           b,
  input  logic [ALU_CTRL_W-1:0] control,
  output logic [31:0]           result,
  output logic                  zero
);

  always_comb begin
    result = '0;
    case (control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
`ifdef EXEC_MEM_XOR_EN
      ALU_XOR: result = a ^ b;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_mem_unit.sv
// Execute + data-memory slice: ALU decoder, ALU, word-addressed RAM; reads are combinational, writes land on the clk edge.
// No flow control; EXEC_MEM_XOR_EN enables funct3=100 -> XOR in the decoder and ALU.
module exec_mem_unit
  import exec_mem_pkg::*;
#(
  parameter int MEM_WORDS = 64
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op5,
  input  logic                  funct7_5,
  input  logic [31:0]           src_a,
  input  logic [31:0]           src_b,
  input  logic                  mem_write,
  input  logic [31:0]           write_data,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [31:0]           alu_result,
  output logic                  zero_flag,
  output logic [31:0]           read_data
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  logic [31:0]       mem [MEM_WORDS];
  logic [ADDR_W-1:0] word_addr;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_LDST:   alu_control = ALU_ADD;
      ALU_OP_BRANCH: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADDSUB: alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLT:    alu_control = ALU_SLT;
          F3_OR:     alu_control = ALU_OR;
          F3_AND:    alu_control = ALU_AND;
`ifdef EXEC_MEM_XOR_EN
          F3_XOR:    alu_control = ALU_XOR;
`endif
          default:   alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

  exec_alu u_alu (
    .a       (src_a),
    .b       (src_b),
    .control (alu_control),
    .result  (alu_result),
    .zero    (zero_flag)
  );

  // Byte offset is dropped and upper bits wrap, so any result maps to a word
  assign word_addr = alu_result[ADDR_W+1:2];
  assign read_data = mem[word_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[word_addr] <= write_data;
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit (MEM_WORDS=64); honours EXEC_MEM_XOR_EN.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mem_write;
  logic [31:0] write_data;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_mem_unit #(.MEM_WORDS(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op5),
    .funct7_5    (funct7_5),
    .src_a       (src_a),
    .src_b       (src_b),
    .mem_write   (mem_write),
    .write_data  (write_data),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .zero_flag   (zero_flag),
    .read_data   (read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply a new input vector between edges and let combinational paths settle
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic o5, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; funct3 = f3; op5 = o5; funct7_5 = f7; src_a = a; src_b = b;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; write_data = '0;
    alu_op = 2'b00; funct3 = 3'b000; op5 = 1'b0; funct7_5 = 1'b0; src_a = '0; src_b = '0;
    edge_settle();
    @(negedge clk);
    reset = 1'b0;

    // Reset state: memory cleared, add of zeros gives zero flag
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_ctrl", {29'b0, alu_control}, 32'h0);
    check("rst_result", alu_result, 32'h0);
    check("rst_zero", {31'b0, zero_flag}, 32'h1);
    check("rst_rd_w0", read_data, 32'h0);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'hFC, 32'h0);
    check("rst_rd_w63", read_data, 32'h0);

    // R-type sub vs. add
    drive(2'b10, 3'b000, 1'b1, 1'b1, 32'd10, 32'd3);
    check("sub_ctrl", {29'b0, alu_control}, 32'h1);
    check("sub_result", alu_result, 32'd7);
    check("sub_zero", {31'b0, zero_flag}, 32'h0);
    drive(2'b10, 3'b000, 1'b0, 1'b1, 32'd10, 32'd3);
    check("addi_ctrl", {29'b0, alu_control}, 32'h0);
    check("addi_result", alu_result, 32'd13);

    // Branch compare, signed slt both ways
    drive(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234);
    check("beq_ctrl", {29'b0, alu_control}, 32'h1);
    check("beq_result", alu_result, 32'h0);
    check("beq_zero", {31'b0, zero_flag}, 32'h1);
    drive(2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1);
    check("slt_ctrl", {29'b0, alu_control}, 32'h5);
    check("slt_neg", alu_result, 32'h1);
    drive(2'b10, 3'b010, 1'b1, 1'b0, 32'h1, 32'hFFFF_FFFF);
    check("slt_pos", alu_result, 32'h0);
    check("slt_pos_zero", {31'b0, zero_flag}, 32'h1);

    // Logic ops, alu_op 11 alias, unknown funct3, add wrap
    drive(2'b10, 3'b110, 1'b1, 1'b0, 32'hF0, 32'h0F);
    check("or_ctrl", {29'b0, alu_control}, 32'h3);
    check("or_result", alu_result, 32'hFF);
    drive(2'b10, 3'b111, 1'b1, 1'b0, 32'hF0, 32'h3C);
    check("and_ctrl", {29'b0, alu_control}, 32'h2);
    check("and_result", alu_result, 32'h30);
    drive(2'b11, 3'b110, 1'b1, 1'b0, 32'h100, 32'h001);
    check("op11_or", alu_result, 32'h101);
    drive(2'b10, 3'b001, 1'b1, 1'b0, 32'd5, 32'd6);
    check("f3_001_ctrl", {29'b0, alu_control}, 32'h0);
    check("f3_001_result", alu_result, 32'd11);
    drive(2'b00, 3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h2);
    check("ldst_wrap", alu_result, 32'h1);

    // Store at 0x104 (word 1): old data until the edge, new after
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h100, 32'h4);
    mem_write = 1'b1; write_data = 32'hDEAD_BEEF;
    #1;
    check("st_before_edge", read_data, 32'h0);
    edge_settle();
    check("st_after_edge", read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_write = 1'b0;

    // Store 0x55 at 0x8 (word 2), read back via 0x10B
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h8, 32'h0);
    mem_write = 1'b1; write_data = 32'h55;
    edge_settle();
    @(negedge clk);
    mem_write = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h10B, 32'h0);
    check("wrap_rd_0x10B", read_data, 32'h55);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h104, 32'h0);
    check("word1_kept", read_data, 32'hDEAD_BEEF);

    // Overwrite word 2: old value visible before the edge
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h8, 32'h0);
    mem_write = 1'b1; write_data = 32'h77;
    #1;
    check("ovw_before", read_data, 32'h55);
    edge_settle();
    check("ovw_after", read_data, 32'h77);
    @(negedge clk);
    mem_write = 1'b0;

    // Write 0xA5 at 4, then reset with mem_write high must win
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h4, 32'h0);
    mem_write = 1'b1; write_data = 32'hA5;
    edge_settle();
    check("a5_written", read_data, 32'hA5);
    @(negedge clk);
    reset = 1'b1; write_data = 32'h1234;
    edge_settle();
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0;
    #1;
    check("rst_over_write", read_data, 32'h0);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'h8, 32'h0);
    check("rst_clears_w2", read_data, 32'h0);

    // Writes resume after reset
    drive(2'b00, 3'b000, 1'b0, 1'b0, 32'hC, 32'h0);
    mem_write = 1'b1; write_data = 32'h99;
    edge_settle();
    check("post_rst_write", read_data, 32'h99);
    @(negedge clk);
    mem_write = 1'b0;

    // funct3=100 depends on the XOR build option
    drive(2'b10, 3'b100, 1'b1, 1'b0, 32'hF0, 32'hFF);
`ifdef EXEC_MEM_XOR_EN
    check("xor_ctrl", {29'b0, alu_control}, 32'h4);
    check("xor_result", alu_result, 32'h0F);
`else
    check("noxor_ctrl", {29'b0, alu_control}, 32'h0);
    check("noxor_result", alu_result, 32'h1EF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
